pipe_skid_reg: RTL and testbench

Parametrised pipeline-stage register, the successor to the plain enabled flop. It replaces the single enable with a valid/ready handshake and adds a 2-entry skid buffer, so back-pressure never drops data and sustained throughput is 1 word/cycle. It also adds a synchronous flush for branch/exception squash and an occupancy output. It sits between datapath stages (IF/ID, ID/EX, ...) and in front of slow consumers such as the memory interface.

---
 rtl/cpu_pipe_pkg.sv | 11 +
 rtl/flopenrv.sv | 20 ++
 rtl/pipe_skid_reg.sv | 105 ++++++++++
 tb/tb_pipe_skid_reg.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-stage constants: occupancy states of the skid register.
// The state encoding doubles as the word count seen on the count port.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/flopenrv.sv
// WIDTH-wide register with synchronous reset to a reset value and a load enable.
module flopenrv #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= RESET_VAL;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake and a 2-entry skid buffer,
// plus synchronous flush and occupancy count. BYPASS=1 turns it into wires.
module pipe_skid_reg
  import cpu_pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               BYPASS    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // Handshake: a word moves on a rising edge where valid & ready are both 1;
  // valid never waits on ready, and a held word is stable until it moves.
  if (BYPASS) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk, rst, flush};
    assign out_valid     = in_valid;
    assign out_data      = in_data;
    assign in_ready      = out_ready;
    assign count         = 2'd0;
  end else begin : g_skid
    skid_state_e      state_q;
    logic             accept;
    logic             consume;
    logic             main_en;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // Handshake flags come only from the state register, so there is no
    // combinational path from the input side to the output side.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign count     = state_q;
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_comb begin
      main_en = 1'b0;
      skid_en = 1'b0;
      main_d  = in_data;
      if (!flush) begin
        unique case (state_q)
          ST_EMPTY: main_en = accept;
          ST_ONE: begin
            main_en = accept & consume;
            skid_en = accept & ~consume;
          end
          ST_FULL: begin
            main_en = consume;
            main_d  = skid_q;
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        state_q <= ST_EMPTY;
      end else begin
        unique case (state_q)
          ST_EMPTY: if (accept) state_q <= ST_ONE;
          ST_ONE: begin
            if (accept && !consume)
              state_q <= ST_FULL;
            else if (!accept && consume)
              state_q <= ST_EMPTY;
          end
          ST_FULL: if (consume) state_q <= ST_ONE;
          default: state_q <= ST_EMPTY;
        endcase
      end
    end

    flopenrv #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
      .clk (clk),
      .rst (rst),
      .en  (main_en),
      .d   (main_d),
      .q   (main_q)
    );

    flopenrv #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
      .clk (clk),
      .rst (rst),
      .en  (skid_en),
      .d   (in_data),
      .q   (skid_q)
    );
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue-based occupancy model checked every cycle,
// directed vectors with literal expectations, and a BYPASS=1 instance.
module tb_pipe_skid_reg;

  localparam int          W     = 32;
  localparam logic [W-1:0] RST_V = 32'hC0DE_0001;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   count;
  logic         bp_in_ready, bp_out_valid;
  logic [W-1:0] bp_out_data;
  logic [1:0]   bp_count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int max_count = 0;

  logic [W-1:0] m_q[$];    // model contents, oldest first
  logic [W-1:0] obs_q[$];  // words seen leaving the DUT
  logic [W-1:0] exp_q[$];

  pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RST_V), .BYPASS(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RST_V), .BYPASS(1'b1)) dut_bp (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(bp_in_ready), .in_data(in_data),
    .out_valid(bp_out_valid), .out_ready(out_ready), .out_data(bp_out_data),
    .count(bp_count)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: a FIFO of at most two words.
  always @(posedge clk) begin
    bit acc, con;
    acc = in_valid && (m_q.size() < 2);
    con = (m_q.size() > 0) && out_ready;
    if (rst || flush) begin
      m_q.delete();
    end else begin
      if (con) void'(m_q.pop_front());
      if (acc) m_q.push_back(in_data);
    end
  end

  // Per-cycle compare and output monitor.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
      chk("cyc_in_ready", {31'd0, in_ready}, {31'd0, m_q.size() < 2});
      chk("cyc_count", {30'd0, count}, m_q.size());
      if (m_q.size() != 0) chk("cyc_out_data", out_data, m_q[0]);
      chk("cyc_bp_out_data", bp_out_data, in_data);
      chk("cyc_bp_in_ready", {31'd0, bp_in_ready}, {31'd0, out_ready});
      if (out_valid && out_ready) obs_q.push_back(out_data);
      if (int'(count) > max_count) max_count = int'(count);
    end
  end

  task automatic chk_obs(input string name);
    chk({name, "_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk(name, obs_q[i], exp_q[i]);
  endtask

  initial begin
    // Reset with a live input word that must be ignored.
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, RST_V);
    chk("rst_count", {30'd0, count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_bp_no_effect", bp_out_data, 32'hDEAD_BEEF);
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Streaming: one word per cycle, latency one cycle, no bubbles.
    obs_q.delete(); max_count = 0;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = i;
      step();
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_data", out_data, i);
    end
    in_valid = 1'b0;
    step(); step();
    exp_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
    chk_obs("stream_order");
    chk("stream_max_count", max_count, 32'd1);

    // Back-pressure fills the skid and holds off the third word.
    obs_q.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    chk("bp_count2", {30'd0, count}, 32'd2);
    chk("bp_in_ready0", {31'd0, in_ready}, 32'd0);
    in_data = 32'hC;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_data", out_data, 32'hA);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    step(); step();
    in_valid = 1'b0;
    step(); step();
    exp_q = '{32'hA, 32'hB, 32'hC};
    chk_obs("bp_order");

    // Flush while FULL, together with an offered word that must be dropped.
    obs_q.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    flush = 1'b1; in_data = 32'hC;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", {30'd0, count}, 32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step(); step(); step();
    chk("flush_nothing_out", obs_q.size(), 32'd0);

    // rst and flush together: rst wins and reloads the data registers.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h77;
    step();
    in_data = 32'h78;
    step();
    chk("prio_pre_full", {30'd0, count}, 32'd2);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0; flush = 1'b0;
    chk("prio_out_data", out_data, RST_V);
    chk("prio_count", {30'd0, count}, 32'd0);

    // BYPASS instance: same-cycle wires.
    in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
    #1;
    chk("byp_data", bp_out_data, 32'h55);
    chk("byp_valid", {31'd0, bp_out_valid}, 32'd1);
    chk("byp_ready0", {31'd0, bp_in_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("byp_ready1", {31'd0, bp_in_ready}, 32'd1);
    chk("byp_count", {30'd0, bp_count}, 32'd0);
    in_valid = 1'b0;
    step(); step();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
